lc3b_line_word_bridge: RTL

Memory-side responder for the cache's 128-bit line port (`lc3b_line`), converting each line read or write into eight sequential 16-bit word transactions on a word-wide physical memory port. It sits between the cache/arbiter and word memory. It acts as the responder on the line side and the initiator on the word side.

---
 rtl/lc3b_line_word_bridge.sv | 118 +++++++++++
 1 files changed

// File: rtl/lc3b_line_word_bridge.sv
// lc3b_line_word_bridge
//   Responder on the cache's 128-bit line port; initiator on a 16-bit word
//   memory port. Each line read/write becomes eight sequential word beats,
//   optionally separated by GAP_CYCLES idle cycles.
//
// Ports
//   clk, reset_n        : clock, asynchronous active-low reset
//   pmem_address/read/write/wdata : line request (level, held until pmem_resp)
//   pmem_rdata, pmem_resp          : assembled read line, one-cycle completion
//   wmem_address/read/write/wdata/byte_enable : word request (level)
//   wmem_rdata, wmem_resp          : word read data, one-cycle word completion
module lc3b_line_word_bridge #(
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [15:0]  pmem_address,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [127:0] pmem_wdata,
  output logic [127:0] pmem_rdata,
  output logic         pmem_resp,
  output logic [15:0]  wmem_address,
  output logic         wmem_read,
  output logic         wmem_write,
  output logic [15:0]  wmem_wdata,
  output logic [1:0]   wmem_byte_enable,
  input  logic [15:0]  wmem_rdata,
  input  logic         wmem_resp
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BEAT,
    S_GAP,
    S_RESP,
    S_DRAIN
  } state_t;

  localparam logic [2:0] GAP_LAST = (GAP_CYCLES > 0) ? 3'(GAP_CYCLES - 1) : 3'd0;

  state_t           state_q, state_d;
  logic [11:0]      line_q;
  logic [2:0]       beat_q;
  logic [2:0]       gap_q;
  logic             dir_rd_q;
  logic [7:0][15:0] wdata_q;
  logic [7:0][15:0] rdata_q;
  logic             strobe;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (pmem_read || pmem_write) state_d = S_BEAT;
      S_BEAT: begin
        if (wmem_resp) begin
          if (beat_q == 3'd7)      state_d = S_RESP;
          else if (GAP_CYCLES > 0) state_d = S_GAP;
          else                     state_d = S_BEAT;
        end
      end
      S_GAP:   if (gap_q == GAP_LAST) state_d = S_BEAT;
      S_RESP:  state_d = S_DRAIN;
      S_DRAIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_q   <= '0;
      beat_q   <= '0;
      gap_q    <= '0;
      dir_rd_q <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (pmem_read || pmem_write) begin
            line_q   <= pmem_address[15:4];
            dir_rd_q <= pmem_read;
            beat_q   <= '0;
            gap_q    <= '0;
            if (!pmem_read) wdata_q <= pmem_wdata;
          end
        end
        S_BEAT: begin
          if (wmem_resp) begin
            // Read words land directly in the output line, so pmem_rdata keeps
            // the previous line until this read's first word is captured.
            if (dir_rd_q) rdata_q[beat_q] <= wmem_rdata;
            if (beat_q != 3'd7) beat_q <= beat_q + 3'd1;
            gap_q <= '0;
          end
        end
        S_GAP:   gap_q <= gap_q + 3'd1;
        default: ;
      endcase
    end
  end

  // Outputs come only from registers and the state decode.
  assign strobe           = (state_q == S_BEAT);
  assign wmem_read        = strobe && dir_rd_q;
  assign wmem_write       = strobe && !dir_rd_q;
  assign wmem_byte_enable = strobe ? 2'b11 : 2'b00;
  assign wmem_address     = {line_q, beat_q, 1'b0};
  assign wmem_wdata       = wdata_q[beat_q];
  assign pmem_rdata       = rdata_q;
  assign pmem_resp        = (state_q == S_RESP);

endmodule
